// File: rtl/osd_text_writer_if.sv
// osd_text_writer_if
//   Bundles the command handshake, the message ROM read port and the
//   character RAM write port of osd_text_writer.
//   cmd_valid/cmd_ready/cmd_op/cmd_row/cmd_col/cmd_msg_id : command channel
//   msg_rom_addr / msg_rom_data                           : message ROM (1-cycle latency)
//   wr_en / wr_addr / wr_data                             : character RAM write port
//   slave  : the writer itself
//   master : command issuer plus ROM/RAM models
interface osd_text_writer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [4:0] cmd_row;
   logic [4:0] cmd_col;
   logic [3:0] cmd_msg_id;
   logic [8:0] msg_rom_addr;
   logic [7:0] msg_rom_data;
   logic       wr_en;
   logic [10:0] wr_addr;
   logic [7:0] wr_data;

   modport slave (
      input  cmd_valid, cmd_op, cmd_row, cmd_col, cmd_msg_id, msg_rom_data,
      output cmd_ready, msg_rom_addr, wr_en, wr_addr, wr_data
   );

   modport master (
      output cmd_valid, cmd_op, cmd_row, cmd_col, cmd_msg_id, msg_rom_data,
      input  cmd_ready, msg_rom_addr, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/osd_text_writer.sv
// osd_text_writer
//   Fills the OSD character RAM from commands (clear / write string / show /
//   hide) and drives the overlay enable, which times out after a number of
//   vblank rising edges.
//   clk        : master clock
//   reset      : synchronous, active low
//   vblank     : vertical blank from video timing
//   bus        : command channel, message ROM port, character RAM write port
//   osd_active : overlay enable (registered)
//   busy       : high whenever a command cannot be accepted
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | cmd_ready high; show/hide execute here in one cycle
//   CLEAR | one blank write per cycle over the whole character RAM
//   FETCH | message ROM address for character idx is on msg_rom_addr
//   WRITE | ROM data valid; write it or terminate the string
module osd_text_writer #(
   parameter int SCREEN_COLS    = 32,
   parameter int SCREEN_ROWS    = 32,
   parameter int MSG_LEN_MAX    = 32,
   parameter int TIMEOUT_FRAMES = 120,
   parameter logic [7:0] BLANK_CHAR = 8'h20
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               vblank,
   osd_text_writer_if.slave   bus,
   output logic               osd_active,
   output logic               busy
);

   localparam int TW = (TIMEOUT_FRAMES == 0) ? 1 : $clog2(TIMEOUT_FRAMES + 1);
   localparam int IW = $clog2(MSG_LEN_MAX + 1);
   localparam logic [10:0] LAST_CELL = 11'(SCREEN_COLS * SCREEN_ROWS - 1);
   localparam logic [TW-1:0] RELOAD  = TW'(TIMEOUT_FRAMES);

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_FETCH, S_WRITE} state_t;

   state_t         state, state_n;
   logic [IW-1:0]  idx, idx_n;
   logic [4:0]     row_q, row_n, col_q, col_n;
   logic [3:0]     id_q, id_n;
   logic           wr_en_q, wr_en_n;
   logic [10:0]    wr_addr_q, wr_addr_n;
   logic [7:0]     wr_data_q, wr_data_n;
   logic [8:0]     rom_addr_q, rom_addr_n;
   logic           active_n;
   logic [TW-1:0]  timer, timer_n;
   logic           vb, vb_d, vb_rise;
   logic           str_done;

   assign vb_rise = vb & ~vb_d;

   assign bus.cmd_ready    = (state == S_IDLE);
   assign busy             = ~bus.cmd_ready;
   assign bus.wr_en        = wr_en_q;
   assign bus.wr_addr      = wr_addr_q;
   assign bus.wr_data      = wr_data_q;
   assign bus.msg_rom_addr = rom_addr_q;

   assign str_done = (bus.msg_rom_data == 8'h00) ||
                     (32'(idx) == MSG_LEN_MAX) ||
                     ((32'(col_q) + 32'(idx)) >= SCREEN_COLS);

   always_comb begin
      state_n    = state;
      idx_n      = idx;
      row_n      = row_q;
      col_n      = col_q;
      id_n       = id_q;
      wr_en_n    = 1'b0;
      wr_addr_n  = wr_addr_q;
      wr_data_n  = wr_data_q;
      rom_addr_n = rom_addr_q;
      active_n   = osd_active;
      timer_n    = timer;

      // Frame countdown; any reload/force below overrides it in the same cycle.
      if (vb_rise && timer != '0) begin
         timer_n = timer - TW'(1);
         if (timer == TW'(1)) active_n = 1'b0;
      end

      case (state)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               case (bus.cmd_op)
                  2'd0: begin
                     state_n   = S_CLEAR;
                     active_n  = 1'b0;
                     timer_n   = '0;
                     wr_en_n   = 1'b1;
                     wr_addr_n = '0;
                     wr_data_n = BLANK_CHAR;
                  end
                  2'd1: begin
                     state_n    = S_FETCH;
                     idx_n      = '0;
                     row_n      = bus.cmd_row;
                     col_n      = bus.cmd_col;
                     id_n       = bus.cmd_msg_id;
                     rom_addr_n = 9'(bus.cmd_msg_id * MSG_LEN_MAX);
                  end
                  2'd2: begin
                     active_n = 1'b1;
                     timer_n  = RELOAD;
                  end
                  default: begin
                     active_n = 1'b0;
                     timer_n  = '0;
                  end
               endcase
            end
         end
         S_CLEAR: begin
            // wr_en is already high on entry, so it is high for every CLEAR cycle.
            if (wr_addr_q == LAST_CELL) begin
               state_n = S_IDLE;
            end else begin
               wr_en_n   = 1'b1;
               wr_addr_n = wr_addr_q + 11'd1;
            end
         end
         S_FETCH: begin
            state_n = S_WRITE;
         end
         S_WRITE: begin
            if (str_done) begin
               state_n  = S_IDLE;
               active_n = 1'b1;
               timer_n  = RELOAD;
            end else begin
               state_n    = S_FETCH;
               wr_en_n    = 1'b1;
               wr_addr_n  = 11'(row_q * SCREEN_COLS + 32'(col_q) + 32'(idx));
               wr_data_n  = bus.msg_rom_data;
               idx_n      = idx + IW'(1);
               rom_addr_n = 9'(id_q * MSG_LEN_MAX + 32'(idx) + 1);
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= S_IDLE;
         idx        <= '0;
         row_q      <= '0;
         col_q      <= '0;
         id_q       <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         rom_addr_q <= '0;
         osd_active <= 1'b0;
         timer      <= '0;
         vb         <= 1'b0;
         vb_d       <= 1'b0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         row_q      <= row_n;
         col_q      <= col_n;
         id_q       <= id_n;
         wr_en_q    <= wr_en_n;
         wr_addr_q  <= wr_addr_n;
         wr_data_q  <= wr_data_n;
         rom_addr_q <= rom_addr_n;
         osd_active <= active_n;
         timer      <= timer_n;
         vb         <= vblank;
         vb_d       <= vb;
      end
   end

endmodule

// File: doc/osd_text_writer.md
Name:
osd_text_writer

Overview:
- Command-driven writer that fills the OSD character RAM read by the 4bpp overlay stage.
- Also generates that stage's `osd_active` enable.
- Accepts clear / write-string / show / hide commands over a valid/ready handshake.
- Write-string copies a NUL-terminated message from a message ROM into the character RAM at a given row/column.
- A frame-based timer, counted on vblank rising edges, drops `osd_active` after a fixed number of frames.

Parameters:
- SCREEN_COLS, 32, characters per row; character RAM address = row*SCREEN_COLS + col.
- SCREEN_ROWS, 32, character rows; clear covers SCREEN_COLS*SCREEN_ROWS cells.
- MSG_LEN_MAX, 32, maximum characters copied per message; also the message ROM stride.
- TIMEOUT_FRAMES, 120, frames `osd_active` stays high after write/show; 0 means it never times out.
- BLANK_CHAR, 8'h20, code written by clear.

Ports:
- clk, in, 1, master clock.
- reset, in, 1, synchronous active-low reset.
- vblank, in, 1, vertical blank from video timing.
- cmd_valid, in, 1, command request.
- cmd_ready, out, 1, high only in IDLE.
- cmd_op, in, 2, opcode: 0 clear, 1 write string, 2 show, 3 hide.
- cmd_row, in, 5, target row (0..SCREEN_ROWS-1).
- cmd_col, in, 5, start column (0..SCREEN_COLS-1).
- cmd_msg_id, in, 4, message index.
- msg_rom_addr, out, 9, message ROM address = msg_id*MSG_LEN_MAX + idx.
- msg_rom_data, in, 8, message ROM data, 1-cycle registered latency.
- wr_en, out, 1, character RAM write strobe.
- wr_addr, out, 11, character RAM write address.
- wr_data, out, 8, character code.
- osd_active, out, 1, overlay enable, registered.
- busy, out, 1, equal to ~cmd_ready.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE; any in-progress operation is abandoned.
  - wr_en=0, wr_addr=0, wr_data=0, msg_rom_addr=0.
  - osd_active=0, timer=0, cmd_ready=1 on the first cycle after release.
- Command acceptance: a command is accepted on a cycle with cmd_valid && cmd_ready. Operands are latched in that cycle; inputs are ignored outside it.
- States: IDLE, CLEAR, FETCH, WRITE.
- IDLE:
  - op0 goes to CLEAR and forces osd_active=0 and timer=0.
  - op1 goes to FETCH with idx=0.
  - op2 sets osd_active=1 and timer=TIMEOUT_FRAMES, then stays in IDLE.
  - op3 sets osd_active=0 and timer=0, then stays in IDLE.
- CLEAR:
  - One write per cycle: wr_en=1, wr_data=BLANK_CHAR, wr_addr=0..SCREEN_COLS*SCREEN_ROWS-1 ascending.
  - After the last address, returns to IDLE.
  - Duration is exactly SCREEN_COLS*SCREEN_ROWS cycles with wr_en high.
- FETCH: drives msg_rom_addr=msg_id*MSG_LEN_MAX+idx with wr_en=0, then goes to WRITE.
- WRITE (msg_rom_data is valid in this state). Terminate, with no write, and return to IDLE if any of:
  - data==8'h00,
  - idx==MSG_LEN_MAX,
  - col+idx>=SCREEN_COLS (no wrap to the next row).
- WRITE, otherwise:
  - wr_en=1, wr_addr=row*SCREEN_COLS+col+idx, wr_data=data.
  - idx increments and the state goes back to FETCH.
  - Each character costs 2 cycles.
- Write-string completion: on returning to IDLE from WRITE, osd_active=1 and timer=TIMEOUT_FRAMES, regardless of how many characters were written.
- Timer:
  - vblank is registered once; a rising edge is vb && !vb_d.
  - On each rising edge with timer>1, timer decrements.
  - On a rising edge with timer==1, timer becomes 0 and osd_active=0 on the next cycle.
  - With TIMEOUT_FRAMES==0, the timer never counts and osd_active holds until hide or clear.
  - Width is ceil(log2(TIMEOUT_FRAMES+1)), minimum 1.
- Simultaneous events: a reload (show, or write completion) in the same cycle as a vblank edge wins, and the timer takes the full reload value. The timer keeps running during CLEAR/FETCH/WRITE of a write command.
- wr_en is never high in IDLE. Outputs are all registered, with no combinational path from cmd_* to wr_*.

Test Plan:
- Reset: hold reset=0 for 3 cycles mid-CLEAR, then release -> next cycle wr_en=0, osd_active=0, cmd_ready=1; no further writes.
- Clear: op0 -> exactly 1024 wr_en pulses, wr_addr 0..1023 consecutive, wr_data=8'h20; cmd_ready returns high the cycle after addr 1023; osd_active=0.
- Write string: ROM msg 2 = "HI",0; op1 row=3 col=5 id=2:
  - msg_rom_addr 64 then 65.
  - Writes (101,'H') and (102,'I') two cycles apart.
  - No third write; osd_active=1 after completion.
- Boundaries:
  - col=30 with 5-char message -> only addrs row*32+30 and +31 written.
  - Message with no NUL -> exactly 32 writes maximum.
- Timeout with TIMEOUT_FRAMES=3: op2, then 3 vblank rising edges -> osd_active falls the cycle after the 3rd edge. A vblank held high for many cycles counts once.
- Reload race: issue op2 on the same cycle as a vblank edge with timer=1 -> osd_active stays 1 and timer=TIMEOUT_FRAMES. op3 then -> osd_active=0 next cycle.
